// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM MMIO control block: register map, bit positions, FSM states.
package gemm_pkg;

    localparam int unsigned DIM_W_DEF = 8;

    localparam logic [2:0] OFF_A_BASE = 3'd0;
    localparam logic [2:0] OFF_B_BASE = 3'd1;
    localparam logic [2:0] OFF_C_BASE = 3'd2;
    localparam logic [2:0] OFF_DIMS   = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;
    localparam logic [2:0] OFF_CYCLES = 3'd6;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_IE      = 1;
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_ERR     = 2;
    localparam int unsigned STAT_TIMEOUT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } state_t;

endpackage

// File: rtl/gemm_cycle_timer.sv
// Saturating operation-cycle counter with a watchdog expiry flag.
module gemm_cycle_timer #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count_inc_c,
    output logic             expired_c
);

    logic [CNT_W-1:0] count;

    // count holds the cycles elapsed before the current one; count_inc_c includes it
    always_comb begin
        count_inc_c = (&count) ? count : count + CNT_W'(1);
        expired_c   = (count >= CNT_W'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count_inc_c;
        end
    end

endmodule

// File: rtl/gemm_mmio_ctrl.sv
// MMIO register file and launch/busy/done sequencing for the GEMM systolic accelerator.
module gemm_mmio_ctrl
    import gemm_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DIM_W          = DIM_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_cs,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rvalid,
    output logic              acc_start,
    output logic [ADDR_W-1:0] acc_a_base,
    output logic [ADDR_W-1:0] acc_b_base,
    output logic [ADDR_W-1:0] acc_c_base,
    output logic [DIM_W-1:0]  acc_m,
    output logic [DIM_W-1:0]  acc_n,
    output logic [DIM_W-1:0]  acc_k,
    input  logic              acc_done,
    output logic              acc_abort,
    output logic              irq
);

    state_t            state, state_n;
    logic              done, err, timeout, ie;
    logic              done_n, err_n, timeout_n, ie_n;
    logic [DATA_W-1:0] cycles;
    logic [DATA_W-1:0] count_inc;
    logic              expired;
    logic              launch, finish, abort, err_set;
    logic              wr, rd, cfg_wr, ctrl_wr, stat_wr, start_req, dims_ok;
    logic [2:0]        reg_sel;
    logic [DATA_W-1:0] rdata_c;
    logic              unused_addr;

    assign unused_addr = ^{bus_addr[ADDR_W-1:5], bus_addr[1:0]};

    gemm_cycle_timer #(
        .CNT_W          (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (launch),
        .enable      (state != IDLE),
        .count_inc_c (count_inc),
        .expired_c   (expired)
    );

    always_comb begin
        reg_sel   = bus_addr[4:2];
        wr        = bus_cs & bus_we;
        rd        = bus_cs & ~bus_we;
        cfg_wr    = wr && (reg_sel <= OFF_DIMS);
        ctrl_wr   = wr && (reg_sel == OFF_CTRL);
        stat_wr   = wr && (reg_sel == OFF_STATUS);
        start_req = ctrl_wr & bus_wdata[CTRL_START];
        dims_ok   = (|acc_m) & (|acc_n) & (|acc_k);
    end

    // Next-state and STATUS/CTRL next values; hardware sets applied last so they beat W1C
    always_comb begin
        state_n   = state;
        launch    = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        err_set   = 1'b0;
        done_n    = done;
        err_n     = err;
        timeout_n = timeout;
        ie_n      = ie;

        case (state)
            IDLE: begin
                if (start_req) begin
                    if (dims_ok) begin
                        state_n = LAUNCH;
                        launch  = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                state_n = BUSY;
                if (acc_done) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            BUSY: begin
                if (acc_done) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end else if (expired) begin
                    finish  = 1'b1;
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if ((state != IDLE) && (cfg_wr || start_req)) begin
            err_set = 1'b1;
        end

        if (ctrl_wr) begin
            ie_n = bus_wdata[CTRL_IE];
        end
        if (stat_wr) begin
            if (bus_wdata[STAT_DONE])    done_n    = 1'b0;
            if (bus_wdata[STAT_ERR])     err_n     = 1'b0;
            if (bus_wdata[STAT_TIMEOUT]) timeout_n = 1'b0;
        end
        if (launch) begin
            done_n    = 1'b0;
            err_n     = 1'b0;
            timeout_n = 1'b0;
        end
        if (finish)  done_n    = 1'b1;
        if (abort)   timeout_n = 1'b1;
        if (err_set) err_n     = 1'b1;
    end

    always_comb begin
        rdata_c = '0;
        case (reg_sel)
            OFF_A_BASE: rdata_c = DATA_W'(acc_a_base);
            OFF_B_BASE: rdata_c = DATA_W'(acc_b_base);
            OFF_C_BASE: rdata_c = DATA_W'(acc_c_base);
            OFF_DIMS:   rdata_c = DATA_W'({acc_k, acc_n, acc_m});
            OFF_CTRL:   rdata_c = DATA_W'({ie, 1'b0});
            OFF_STATUS: rdata_c = DATA_W'({timeout, err, done, state != IDLE});
            OFF_CYCLES: rdata_c = cycles;
            default:    rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
            ie         <= 1'b0;
            irq        <= 1'b0;
            acc_start  <= 1'b0;
            acc_abort  <= 1'b0;
            cycles     <= '0;
            acc_a_base <= '0;
            acc_b_base <= '0;
            acc_c_base <= '0;
            acc_m      <= '0;
            acc_n      <= '0;
            acc_k      <= '0;
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
        end else begin
            state      <= state_n;
            done       <= done_n;
            err        <= err_n;
            timeout    <= timeout_n;
            ie         <= ie_n;
            irq        <= done_n & ie_n;
            acc_start  <= launch;
            acc_abort  <= abort;
            bus_rvalid <= rd;
            bus_rdata  <= rd ? rdata_c : '0;
            if (finish) begin
                cycles <= count_inc;
            end
            // Operand configuration is frozen while an operation is in flight
            if (cfg_wr && (state == IDLE)) begin
                case (reg_sel)
                    OFF_A_BASE: acc_a_base <= ADDR_W'(bus_wdata);
                    OFF_B_BASE: acc_b_base <= ADDR_W'(bus_wdata);
                    OFF_C_BASE: acc_c_base <= ADDR_W'(bus_wdata);
                    default: begin
                        acc_m <= bus_wdata[0 +: DIM_W];
                        acc_n <= bus_wdata[DIM_W +: DIM_W];
                        acc_k <= bus_wdata[2*DIM_W +: DIM_W];
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gemm_mmio_ctrl.sv
// Directed self-checking bench for gemm_mmio_ctrl with a 16-cycle watchdog.
module tb_gemm_mmio_ctrl;

    localparam logic [31:0] A_A    = 32'h00;
    localparam logic [31:0] A_B    = 32'h04;
    localparam logic [31:0] A_C    = 32'h08;
    localparam logic [31:0] A_DIMS = 32'h0C;
    localparam logic [31:0] A_CTRL = 32'h10;
    localparam logic [31:0] A_STAT = 32'h14;
    localparam logic [31:0] A_CYC  = 32'h18;
    localparam logic [31:0] A_R7   = 32'h1C;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_cs, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_rvalid;
    logic        acc_start, acc_done, acc_abort, irq;
    logic [31:0] acc_a_base, acc_b_base, acc_c_base;
    logic [7:0]  acc_m, acc_n, acc_k;

    int total = 0;
    int bad   = 0;
    int starts = 0;
    int aborts = 0;

    gemm_mmio_ctrl #(
        .ADDR_W(32), .DATA_W(32), .DIM_W(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .acc_start(acc_start), .acc_a_base(acc_a_base), .acc_b_base(acc_b_base),
        .acc_c_base(acc_c_base), .acc_m(acc_m), .acc_n(acc_n), .acc_k(acc_k),
        .acc_done(acc_done), .acc_abort(acc_abort), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (acc_start === 1'b1) starts++;
        if (acc_abort === 1'b1) aborts++;
    end

    // Bus tasks are entered on a falling edge and return on the next falling edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_cs = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_cs = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        bus_cs = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(negedge clk);
        d = bus_rdata; v = bus_rvalid;
        bus_cs = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        rst = 1'b1; bus_cs = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; acc_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({acc_start, acc_abort, irq, bus_rvalid} !== 4'b0) begin
            $display("FAIL reset_pulses got=%b exp=0000", {acc_start, acc_abort, irq, bus_rvalid}); bad++;
        end
        total++;
        if ({acc_a_base, acc_m, acc_n, acc_k} !== 56'h0) begin
            $display("FAIL reset_cfg got=%h exp=0", {acc_a_base, acc_m, acc_n, acc_k}); bad++;
        end
        bus_read(A_STAT, d, v);
        total++;
        if ({v, d} !== {1'b1, 32'h0}) begin
            $display("FAIL reset_status got=%b/%h exp=1/0", v, d); bad++;
        end
        @(negedge clk);
        total++;
        if (bus_rvalid !== 1'b0) begin
            $display("FAIL rvalid_pulse got=%b exp=0", bus_rvalid); bad++;
        end
    endtask

    task automatic test_launch();
        logic [31:0] d; logic v; int s0;
        s0 = starts;
        bus_write(A_A, 32'h1000);
        bus_write(A_B, 32'h2000);
        bus_write(A_C, 32'h3000);
        bus_write(A_DIMS, 32'h040404);
        bus_write(A_CTRL, 32'h3);
        total++;
        if (acc_start !== 1'b1) begin
            $display("FAIL launch_pulse got=%b exp=1", acc_start); bad++;
        end
        bus_read(A_STAT, d, v);
        total++;
        if (d !== 32'h1) begin
            $display("FAIL launch_busy got=%h exp=1", d); bad++;
        end
        total++;
        if (acc_start !== 1'b0) begin
            $display("FAIL launch_single got=%b exp=0", acc_start); bad++;
        end
        repeat (9) @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        total++;
        if (irq !== 1'b1) begin
            $display("FAIL launch_irq got=%b exp=1", irq); bad++;
        end
        total++;
        if ({acc_a_base, acc_b_base, acc_c_base} !== {32'h1000, 32'h2000, 32'h3000}) begin
            $display("FAIL launch_bases got=%h exp=100020003000", {acc_a_base, acc_b_base, acc_c_base}); bad++;
        end
        total++;
        if ({acc_k, acc_n, acc_m} !== 24'h040404) begin
            $display("FAIL launch_dims got=%h exp=040404", {acc_k, acc_n, acc_m}); bad++;
        end
        bus_read(A_STAT, d, v);
        total++;
        if (d !== 32'h2) begin
            $display("FAIL launch_status got=%h exp=2", d); bad++;
        end
        bus_read(A_CYC, d, v);
        total++;
        if (d !== 32'd11) begin
            $display("FAIL launch_cycles got=%0d exp=11", d); bad++;
        end
        bus_read(A_CTRL, d, v);
        total++;
        if (d !== 32'h2) begin
            $display("FAIL ctrl_readback got=%h exp=2", d); bad++;
        end
        total++;
        if (starts - s0 !== 1) begin
            $display("FAIL launch_count got=%0d exp=1", starts - s0); bad++;
        end
    endtask

    task automatic test_bad_dims();
        logic [31:0] d; logic v; int s0;
        bus_write(A_STAT, 32'h2);
        bus_write(A_DIMS, 32'h000404);
        s0 = starts;
        bus_write(A_CTRL, 32'h3);
        @(negedge clk);
        bus_read(A_STAT, d, v);
        total++;
        if (d !== 32'h4) begin
            $display("FAIL bad_dims_status got=%h exp=4", d); bad++;
        end
        total++;
        if ((starts - s0) !== 0 || irq !== 1'b0) begin
            $display("FAIL bad_dims_no_launch got=%0d/%b exp=0/0", starts - s0, irq); bad++;
        end
    endtask

    task automatic test_busy_lock();
        logic [31:0] d; logic v; int s0;
        bus_write(A_DIMS, 32'h040404);
        s0 = starts;
        bus_write(A_CTRL, 32'h3);
        bus_write(A_A, 32'hDEAD);
        bus_write(A_CTRL, 32'h3);
        total++;
        if (acc_a_base !== 32'h1000) begin
            $display("FAIL lock_a_base got=%h exp=1000", acc_a_base); bad++;
        end
        bus_read(A_STAT, d, v);
        total++;
        if (d !== 32'h5) begin
            $display("FAIL lock_status got=%h exp=5", d); bad++;
        end
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        bus_read(A_STAT, d, v);
        total++;
        if (d !== 32'h6) begin
            $display("FAIL lock_done_status got=%h exp=6", d); bad++;
        end
        bus_read(A_A, d, v);
        total++;
        if (d !== 32'h1000 || (starts - s0) !== 1) begin
            $display("FAIL lock_single_launch got=%h/%0d exp=1000/1", d, starts - s0); bad++;
        end
        bus_write(A_STAT, 32'h6);
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic v; int a0;
        a0 = aborts;
        bus_write(A_CTRL, 32'h3);
        repeat (16) @(negedge clk);
        total++;
        if (acc_abort !== 1'b0) begin
            $display("FAIL abort_early got=%b exp=0", acc_abort); bad++;
        end
        @(negedge clk);
        total++;
        if (acc_abort !== 1'b1) begin
            $display("FAIL abort_pulse got=%b exp=1", acc_abort); bad++;
        end
        @(negedge clk);
        total++;
        if (acc_abort !== 1'b0 || (aborts - a0) !== 1) begin
            $display("FAIL abort_single got=%b/%0d exp=0/1", acc_abort, aborts - a0); bad++;
        end
        bus_read(A_STAT, d, v);
        total++;
        if (d !== 32'hA || irq !== 1'b1) begin
            $display("FAIL timeout_status got=%h/%b exp=a/1", d, irq); bad++;
        end
        bus_read(A_CYC, d, v);
        total++;
        if (d !== 32'd17) begin
            $display("FAIL timeout_cycles got=%0d exp=17", d); bad++;
        end
        bus_write(A_STAT, 32'hA);
        bus_read(A_STAT, d, v);
        total++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            $display("FAIL w1c_clear got=%h/%b exp=0/0", d, irq); bad++;
        end
    endtask

    task automatic test_done_vs_expiry();
        logic [31:0] d; logic v; int a0;
        a0 = aborts;
        bus_write(A_CTRL, 32'h3);
        repeat (16) @(negedge clk);
        acc_done = 1'b1;
        bus_write(A_STAT, 32'h2);
        acc_done = 1'b0;
        total++;
        if (acc_abort !== 1'b0) begin
            $display("FAIL race_abort got=%b exp=0", acc_abort); bad++;
        end
        bus_read(A_STAT, d, v);
        total++;
        if (d !== 32'h2) begin
            $display("FAIL race_status got=%h exp=2", d); bad++;
        end
        bus_read(A_CYC, d, v);
        total++;
        if (d !== 32'd17 || (aborts - a0) !== 0) begin
            $display("FAIL race_cycles got=%0d/%0d exp=17/0", d, aborts - a0); bad++;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d; logic v;
        bus_write(A_CTRL, 32'h3);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({acc_start, acc_abort, irq, bus_rvalid, acc_a_base, acc_b_base, acc_c_base, acc_m, acc_n, acc_k} !== 124'h0) begin
            $display("FAIL async_reset_outputs got=%h exp=0",
                     {acc_start, acc_abort, irq, bus_rvalid, acc_a_base, acc_b_base, acc_c_base, acc_m, acc_n, acc_k});
            bad++;
        end
        @(negedge clk);
        rst = 1'b0;
        bus_read(A_STAT, d, v);
        total++;
        if (d !== 32'h0) begin
            $display("FAIL reset_idle got=%h exp=0", d); bad++;
        end
        bus_read(A_CYC, d, v);
        total++;
        if (d !== 32'h0) begin
            $display("FAIL reset_cycles got=%h exp=0", d); bad++;
        end
        bus_read(A_CTRL, d, v);
        total++;
        if (d !== 32'h0) begin
            $display("FAIL reset_ctrl got=%h exp=0", d); bad++;
        end
        bus_write(A_R7, 32'hFFFF_FFFF);
        bus_read(A_R7, d, v);
        total++;
        if ({v, d} !== {1'b1, 32'h0}) begin
            $display("FAIL addr7_read got=%b/%h exp=1/0", v, d); bad++;
        end
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_launch();
        test_bad_dims();
        test_busy_lock();
        test_timeout();
        test_done_vs_expiry();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
